imem_boot_loader: RTL and testbench

Writer-side counterpart of the CPU instruction fetch path. Accepts a framed byte stream, packs it big-endian into 32-bit words, and writes them into a 64-word instruction RAM. The RAM exposes the same two asynchronous read ports the CPU fetch unit uses. The block holds the CPU in reset until a complete, valid image is loaded, so a program can be booted without rebuilding the ROM image.

---
 rtl/imem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream (length byte, then
// big-endian 32-bit words) and writes it into a 2**ADDR_W-word instruction
// RAM with two asynchronous read ports. The CPU is held in reset until the
// complete image has been accepted.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds a 4-byte trailer that
// must equal the XOR of all written words.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [31:0]       RD1,
    output logic [31:0]       RD2,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [8:0]      DEPTH_LEN = 9'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

`ifdef IMEM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_WORDS, S_CSUM, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_LEN, S_WORDS, S_DONE, S_ERROR} state_t;
`endif

    state_t            state, state_next;
    logic [ADDR_W:0]   n_words, n_words_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [1:0]        byte_idx, byte_idx_next;
    logic [23:0]       asm_r, asm_next;
    logic              ready_next, done_next, err_next, cpu_rst_next;
    logic              xfer, we, len_ok, last_word;
    logic [31:0]       word;
    logic [31:0]       mem [DEPTH];
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]       xor_acc, xor_next;
`endif

    assign xfer      = in_valid && in_ready;
    assign word      = {asm_r, in_data};
    assign len_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH_LEN);
    assign last_word = (({1'b0, addr} + CNT_ONE) == n_words);

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_next    = state;
        n_words_next  = n_words;
        addr_next     = addr;
        byte_idx_next = byte_idx;
        asm_next      = asm_r;
        we            = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        xor_next      = xor_acc;
`endif
        case (state)
            S_LEN: begin
                if (xfer) begin
                    if (len_ok) begin
                        n_words_next  = in_data[ADDR_W:0];
                        addr_next     = '0;
                        byte_idx_next = '0;
                        state_next    = S_WORDS;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_WORDS: begin
                if (xfer) begin
                    byte_idx_next = byte_idx + 2'd1;
                    asm_next      = {asm_r[15:0], in_data};
                    if (byte_idx == 2'd3) begin
                        we = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        xor_next = xor_acc ^ word;
`endif
                        // addr is held on the last word so it never wraps at N == DEPTH
                        if (last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                            state_next = S_CSUM;
`else
                            state_next = S_DONE;
`endif
                        end else begin
                            addr_next = addr + 1'b1;
                        end
                    end
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    byte_idx_next = byte_idx + 2'd1;
                    asm_next      = {asm_r[15:0], in_data};
                    if (byte_idx == 2'd3) begin
                        state_next = (word == xor_acc) ? S_DONE : S_ERROR;
                    end
                end
            end
`endif
            default: begin
                state_next = state;
            end
        endcase

        ready_next   = (state_next == S_LEN) || (state_next == S_WORDS)
`ifdef IMEM_LOAD_CHECKSUM_EN
                       || (state_next == S_CSUM)
`endif
                       ;
        done_next    = (state_next == S_DONE);
        err_next     = (state_next == S_ERROR);
        cpu_rst_next = (state_next != S_DONE);
    end

    // FSM state, load counters and registered handshake/status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_LEN;
            n_words  <= '0;
            addr     <= '0;
            byte_idx <= '0;
            asm_r    <= '0;
            in_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rst  <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            state    <= state_next;
            n_words  <= n_words_next;
            addr     <= addr_next;
            byte_idx <= byte_idx_next;
            asm_r    <= asm_next;
            in_ready <= ready_next;
            done     <= done_next;
            err      <= err_next;
            cpu_rst  <= cpu_rst_next;
`ifdef IMEM_LOAD_CHECKSUM_EN
            xor_acc  <= xor_next;
`endif
        end
    end

    // Instruction RAM write port; contents deliberately survive RST
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= word;
        end
    end

    assign RD1 = mem[A1];
    assign RD2 = mem[A2];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (ADDR_W = 6, DEPTH = 64).
module tb_imem_boot_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  A1, A2;
    logic [31:0] RD1, RD2;
    logic        cpu_rst, done, err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] tb_xor;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [7:0] len;
        logic       exp_err;
        logic       exp_ready;
    } len_vec_t;
    len_vec_t lv[5];

    imem_boot_loader #(.ADDR_W(6)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // Offer one byte and return at the falling edge after it transferred.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
            in_valid = 1'b0;
            return;
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [5:0] a, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
        sb.push_back('{a, w});
        tb_xor ^= w;
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic send_trailer(input logic [31:0] x);
        for (int i = 3; i >= 0; i--) send_byte(x[i*8 +: 8]);
    endtask
`endif

    // Pop every expected write and compare it on both read ports.
    task automatic drain();
        wr_t e;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            A1 = e.a;
            A2 = e.a;
            #1;
            check("rd1_sb", RD1, e.d);
            check("rd2_sb", RD2, e.d);
        end
        @(negedge CLK);
    endtask

    initial begin
        lv[0] = '{8'h00, 1'b1, 1'b0};
        lv[1] = '{8'h41, 1'b1, 1'b0};
        lv[2] = '{8'hFF, 1'b1, 1'b0};
        lv[3] = '{8'h40, 1'b0, 1'b1};
        lv[4] = '{8'h01, 1'b0, 1'b1};

        in_valid = 1'b0;
        in_data  = 8'h00;
        A1 = '0;
        A2 = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        RST = 1'b0;
        @(negedge CLK);

        // Basic two-word load
        tb_xor = '0;
        send_byte(8'd2);
        send_word(6'd0, 32'h2408_0005);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("basic_done_early", {31'd0, done}, 32'd0);
        check("basic_cpu_rst_early", {31'd0, cpu_rst}, 32'd1);
        send_byte(8'h0C);
        sb.push_back('{6'd1, 32'h0000_000C});
        tb_xor ^= 32'h0000_000C;
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_trailer(tb_xor);
`endif
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("basic_ready", {31'd0, in_ready}, 32'd0);
        A1 = 6'd0;
        A2 = 6'd1;
        #1;
        check("basic_rd1", RD1, 32'h2408_0005);
        check("basic_rd2", RD2, 32'h0000_000C);
        drain();

        // A byte held while done is not consumed
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (3) @(negedge CLK);
        check("hold_ready", {31'd0, in_ready}, 32'd0);
        check("hold_done", {31'd0, done}, 32'd1);
        in_valid = 1'b0;
        A1 = 6'd0;
        #1;
        check("hold_mem0", RD1, 32'h2408_0005);
        @(negedge CLK);

        // Backpressure: valid pattern 1,0,0,1,1,0,1 carries 4 bytes
        do_reset();
        tb_xor = '0;
        send_byte(8'd1);
        begin
            logic [31:0] w;
            logic [6:0]  pat;
            int unsigned k;
            w   = 32'hA1B2_C3D4;
            pat = 7'b1011001;
            k   = 0;
            for (int i = 0; i < 7; i++) begin
                in_valid = pat[i];
                in_data  = pat[i] ? w[(3 - k)*8 +: 8] : 8'hEE;
                @(negedge CLK);
                if (pat[i]) k++;
            end
            in_valid = 1'b0;
            sb.push_back('{6'd0, w});
            tb_xor ^= w;
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_trailer(tb_xor);
`endif
        check("bp_done", {31'd0, done}, 32'd1);
        drain();

        // Mid-load reset, then a one-word reload
        do_reset();
        tb_xor = '0;
        send_byte(8'd3);
        send_word(6'd0, 32'h1111_1111);
        send_byte(8'h22);
        do_reset();
        check("mid_ready", {31'd0, in_ready}, 32'd1);
        check("mid_done", {31'd0, done}, 32'd0);
        drain();
        tb_xor = '0;
        send_byte(8'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        check("mid_done_early", {31'd0, done}, 32'd0);
        send_byte(8'hEF);
        sb.push_back('{6'd0, 32'hDEAD_BEEF});
        tb_xor ^= 32'hDEAD_BEEF;
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_trailer(tb_xor);
`endif
        check("mid_done", {31'd0, done}, 32'd1);
        check("mid_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        drain();
        A1 = 6'd1;
        #1;
        check("mid_mem1_kept", RD1, 32'h0000_000C);
        @(negedge CLK);

        // Length byte table
        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_byte(lv[i].len);
            check($sformatf("len%0d_err", i), {31'd0, err}, {31'd0, lv[i].exp_err});
            check($sformatf("len%0d_ready", i), {31'd0, in_ready}, {31'd0, lv[i].exp_ready});
            check($sformatf("len%0d_cpu_rst", i), {31'd0, cpu_rst}, 32'd1);
            check($sformatf("len%0d_done", i), {31'd0, done}, 32'd0);
        end

        // Full depth
        do_reset();
        tb_xor = '0;
        send_byte(8'd64);
        for (int i = 0; i < 64; i++) send_word(6'(i), 32'(i));
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_trailer(tb_xor);
`endif
        check("full_done", {31'd0, done}, 32'd1);
        check("full_err", {31'd0, err}, 32'd0);
        A1 = 6'd63;
        #1;
        check("full_rd63", RD1, 32'd63);
        @(negedge CLK);
        drain();

`ifdef IMEM_LOAD_CHECKSUM_EN
        // Checksum trailer good and bad
        do_reset();
        send_byte(8'd2);
        send_word(6'd0, 32'h0000_FFFF);
        send_word(6'd1, 32'h00FF_00FF);
        send_trailer(32'h00FF_FF00);
        check("csum_ok_done", {31'd0, done}, 32'd1);
        check("csum_ok_err", {31'd0, err}, 32'd0);
        drain();
        do_reset();
        send_byte(8'd2);
        send_word(6'd0, 32'h0000_FFFF);
        send_word(6'd1, 32'h00FF_00FF);
        send_trailer(32'h00FF_FF01);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("csum_bad_done", {31'd0, done}, 32'd0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
